maze_map_arbiter: RTL
=====================

# maze_map_arbiter

Shares the single-port maze map ROM between the VGA render path and the game-logic collision path. Render reads are latency-critical and win by default. A bounded-wait counter guarantees the logic requester a slot, at the cost of deferring one render read by exactly one cycle. The block sits between the map ROM and its two consumers, replacing direct ROM address muxing in the top level.

## Interface
- ADDR_W, 5: map row address width (21 rows).
- DATA_W, 21: map row word width (one bit per maze cell).
- ROM_LAT, 1: ROM read latency in cycles from rom_en to rom_data valid. Legal range 1–3.
- MAX_WAIT, 4: cycles an issued-pending logic request may lose arbitration before it is forced. Must be ≥2.

Ports:
- clk, in, 1: system clock (100 MHz).
- reset, in, 1: synchronous, active-high.
- ren_req, in, 1: render read request, single-cycle pulse.
- ren_addr, in, ADDR_W: render row address, valid with ren_req.
- ren_rvalid, out, 1: render data valid pulse.
- ren_rdata, out, DATA_W: render row data.
- ren_overrun, out, 1: sticky; a render request was dropped.
- lg_req, in, 1: logic request, level, held until lg_ack.
- lg_addr, in, ADDR_W: logic row address, stable while lg_req is high.
- lg_ack, out, 1: one-cycle pulse; lg_rdata is valid this cycle.
- lg_rdata, out, DATA_W: logic row data.
- rom_en, out, 1: ROM read strobe, registered.
- rom_addr, out, ADDR_W: ROM address, registered.
- rom_data, in, DATA_W: ROM read data.

## Operation
- State:
  - render pending slot (rp_valid, rp_addr);
  - logic state LG_IDLE / LG_WAIT / LG_INFLIGHT;
  - wait counter wcnt (saturating at MAX_WAIT);
  - tag shift register, depth ROM_LAT, entries {valid, src}.
- Render candidate each cycle: the pending slot if rp_valid, else ren_req.
- Logic candidate: lg_req high and state LG_IDLE or LG_WAIT. LG_IDLE moves to LG_WAIT on lg_req.
- Grant rule:
  - If there is a logic candidate and (no render candidate, or wcnt == MAX_WAIT), grant logic.
  - Otherwise grant render if there is a render candidate.
- On a logic grant while ren_req is high:
  - ren_req is captured into the pending slot.
  - If rp_valid was already set, the older pending entry is dropped and ren_overrun is set.
- On a render grant of the pending slot while ren_req is high: ren_req becomes the new pending entry.
- wcnt increments each cycle the logic candidate loses, and clears on the logic grant.
- A grant drives rom_en=1 and rom_addr on the next cycle, and pushes {1, src} into the tag pipe.
- Logic grant: state becomes LG_INFLIGHT. No reissue until ack.
- Response: when the tag exits the pipe (aligned with rom_data valid), rom_data is registered into the matching rdata.
  - ren_rvalid or lg_ack pulses on the following cycle.
  - On lg_ack, the logic state returns to LG_IDLE.
- lg_req dropping while LG_WAIT: the request is withdrawn, state returns to LG_IDLE, and wcnt clears.
- lg_req dropping while LG_INFLIGHT: the read completes and lg_ack still pulses.
- rdata registers hold their last value between valid pulses.

## Timing
- Reset values:
  - rom_en=0, rom_addr=0;
  - ren_rvalid=0, ren_rdata=0, ren_overrun=0;
  - lg_ack=0, lg_rdata=0;
  - rp_valid=0, tag pipe cleared, wcnt=0, LG_IDLE.
- Reset mid-operation: in-flight reads produce no response, and rom_data is ignored until new grants.
- Latency, undeferred render: ren_req at cycle T → rom_en at T+1 → ren_rvalid at T+2+ROM_LAT (T+3 when ROM_LAT=1).
- Latency, deferred render: exactly one cycle more.
- Logic latency when uncontended: lg_req first high at T → lg_ack at T+2+ROM_LAT.
- Worst-case logic wait: MAX_WAIT lost cycles, then a forced grant. lg_ack no later than T+MAX_WAIT+2+ROM_LAT.
- Throughput: one ROM read per cycle, at most one grant per cycle.
- Simultaneous events: render and logic requests in the same cycle with wcnt < MAX_WAIT → render granted.
- ren_overrun clears only on reset.

## Test plan
- Single render read, ROM_LAT=1, ren_addr=7, ROM row 7 = 21'h1ABCDE:
  - rom_en=1 and rom_addr=7 at T+1;
  - ren_rvalid=1 and ren_rdata=21'h1ABCDE at T+3;
  - no lg_ack.
- Lone logic read, lg_addr=20: lg_ack at T+3 with row 20 data. lg_req held through ack yields no second rom_en.
- Contention, ren_req every cycle, lg_req high from T, MAX_WAIT=4:
  - render wins T..T+3;
  - logic forced at T+4, and the T+4 render request is issued at T+5;
  - every render request answered in order, ren_overrun stays 0.
- Render at the 25 MHz pace (every 4th cycle) plus logic: logic is granted in a gap cycle with wcnt < MAX_WAIT, and no render is deferred.
- Reset asserted one cycle after a render grant: no ren_rvalid afterwards, and all outputs are 0 on the cycle after reset.
- lg_req withdrawn in LG_WAIT: no rom_en for logic and no lg_ack. A subsequent lg_req starts with wcnt=0.

Source files
------------

// File: rtl/maze_map_arbiter.sv
// Arbitrates the single-port maze map ROM between the render path (priority)
// and the game-logic path (level request, bounded wait before a forced grant).
module maze_map_arbiter #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 21,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ren_req,
  input  logic [ADDR_W-1:0] ren_addr,
  output logic              ren_rvalid,
  output logic [DATA_W-1:0] ren_rdata,
  output logic              ren_overrun,
  input  logic              lg_req,
  input  logic [ADDR_W-1:0] lg_addr,
  output logic              lg_ack,
  output logic [DATA_W-1:0] lg_rdata,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    LG_IDLE,
    LG_WAIT,
    LG_INFLIGHT
  } lg_state_e;

  lg_state_e           lg_state_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic                rp_valid_q, rp_valid_d;
  logic [ADDR_W-1:0]   rp_addr_q, rp_addr_d;
  logic                rp_drop;
  logic                rom_en_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic                iss_lg_q;
  logic [ROM_LAT-1:0]  tag_v_q;
  logic [ROM_LAT-1:0]  tag_lg_q;
  logic                ren_rvalid_q, ren_overrun_q, lg_ack_q;
  logic [DATA_W-1:0]   ren_rdata_q, lg_rdata_q;

  logic                ren_cand, lg_cand, wcnt_full;
  logic [ADDR_W-1:0]   ren_cand_addr;
  logic                grant_lg, grant_ren;
  logic                tag_exit_v, tag_exit_lg;

  assign ren_cand      = rp_valid_q | ren_req;
  assign ren_cand_addr = rp_valid_q ? rp_addr_q : ren_addr;
  assign lg_cand       = lg_req && (lg_state_q != LG_INFLIGHT);
  assign wcnt_full     = (wcnt_q == WCNT_W'(MAX_WAIT));
  assign grant_lg      = lg_cand && (!ren_cand || wcnt_full);
  assign grant_ren     = ren_cand && !grant_lg;
  assign tag_exit_v    = tag_v_q[ROM_LAT-1];
  assign tag_exit_lg   = tag_lg_q[ROM_LAT-1];

  // A logic grant parks the concurrent render request; serving the parked one
  // parks the new one, so a deferred render stays exactly one cycle late.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    rp_valid_d = rp_valid_q;
    rp_addr_d  = rp_addr_q;
    rp_drop    = 1'b0;
    if (grant_lg && ren_req) begin
      rp_drop    = rp_valid_q;
      rp_valid_d = 1'b1;
      rp_addr_d  = ren_addr;
    end else if (grant_ren && rp_valid_q) begin
      rp_valid_d = ren_req;
      if (ren_req) rp_addr_d = ren_addr;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the tag pipe and data registers are reset too, so reads in flight at
    // reset can never raise a response from stale rom_data.
    if (reset) begin
      lg_state_q    <= LG_IDLE;
      wcnt_q        <= '0;
      rp_valid_q    <= 1'b0;
      rp_addr_q     <= '0;
      rom_en_q      <= 1'b0;
      rom_addr_q    <= '0;
      iss_lg_q      <= 1'b0;
      tag_v_q       <= '0;
      tag_lg_q      <= '0;
      ren_rvalid_q  <= 1'b0;
      ren_rdata_q   <= '0;
      ren_overrun_q <= 1'b0;
      lg_ack_q      <= 1'b0;
      lg_rdata_q    <= '0;
    end else begin
      // NOTE: sequential state uses <= only, so every register sees pre-edge values.
      rom_en_q <= grant_lg | grant_ren;
      iss_lg_q <= grant_lg;
      if (grant_lg)       rom_addr_q <= lg_addr;
      else if (grant_ren) rom_addr_q <= ren_cand_addr;

      tag_v_q[0]  <= rom_en_q;
      tag_lg_q[0] <= iss_lg_q;
      for (int i = 1; i < int'(ROM_LAT); i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_lg_q[i] <= tag_lg_q[i-1];
      end

      ren_rvalid_q <= tag_exit_v && !tag_exit_lg;
      lg_ack_q     <= tag_exit_v && tag_exit_lg;
      if (tag_exit_v && !tag_exit_lg) ren_rdata_q <= rom_data;
      if (tag_exit_v && tag_exit_lg)  lg_rdata_q  <= rom_data;

      rp_valid_q    <= rp_valid_d;
      rp_addr_q     <= rp_addr_d;
      ren_overrun_q <= ren_overrun_q | rp_drop;

      if (grant_lg || !lg_cand)  wcnt_q <= '0;
      else if (!wcnt_full)       wcnt_q <= wcnt_q + WCNT_W'(1);

      // INFLIGHT is left only after the ack cycle, so a requester still holding
      // lg_req during the ack does not trigger a second read.
      case (lg_state_q)
        LG_IDLE:     if (grant_lg) lg_state_q <= LG_INFLIGHT;
                     else if (lg_req) lg_state_q <= LG_WAIT;
        LG_WAIT:     if (grant_lg) lg_state_q <= LG_INFLIGHT;
                     else if (!lg_req) lg_state_q <= LG_IDLE;
        LG_INFLIGHT: if (lg_ack_q) lg_state_q <= LG_IDLE;
        default:     lg_state_q <= LG_IDLE;
      endcase
    end
  end

  assign ren_rvalid  = ren_rvalid_q;
  assign ren_rdata   = ren_rdata_q;
  assign ren_overrun = ren_overrun_q;
  assign lg_ack      = lg_ack_q;
  assign lg_rdata    = lg_rdata_q;
  assign rom_en      = rom_en_q;
  assign rom_addr    = rom_addr_q;

endmodule
